// File: rtl/mem_arbiter_rr_if.sv
// Requester-side and RAM-side signals of the round-robin shared-memory arbiter.
// The arbiter connects through the slave modport; cores and the RAM sit on the master side.
interface mem_arbiter_rr_if #(
  parameter int NCH = 16,
  parameter int AW  = 8,
  parameter int DW  = 8
);
  logic [NCH-1:0]    rden;
  logic [NCH-1:0]    wren;
  logic [NCH*AW-1:0] Address;
  logic [NCH*DW-1:0] Din;
  logic [NCH-1:0]    acq;
  logic [NCH*DW-1:0] Dq;
  logic [DW-1:0]     RAMq;
  logic [AW-1:0]     RAMAddress;
  logic [DW-1:0]     RAMDin;
  logic              RAMwren;
  logic              busy;

  modport master (
    output rden, wren, Address, Din, RAMq,
    input  acq, Dq, RAMAddress, RAMDin, RAMwren, busy
  );

  modport slave (
    input  rden, wren, Address, Din, RAMq,
    output acq, Dq, RAMAddress, RAMDin, RAMwren, busy
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter letting NCH requesters share one single-port synchronous RAM.
// Grants one transaction at a time; read data is held per channel in the Dq slices.
module mem_arbiter_rr #(
  parameter int NCH    = 16,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            srst,
  mem_arbiter_rr_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    CAP  = 3'd4,
    ACK  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     ptr_r;
  logic [NCH-1:0]    req_s;
  logic [CW:0]       pick_s;
  logic              grant_s;
  logic [CW-1:0]     win_s;
  logic [NCH-1:0]    acq_r;
  logic [NCH*DW-1:0] dq_r;
  logic [AW-1:0]     ram_addr_r;
  logic [DW-1:0]     ram_din_r;
  logic              ram_wren_r;
  logic              busy_r;

  // First requester after ptr in circular order; the MSB flags that any request exists.
  // Scanning from the far end lets the nearest channel overwrite earlier candidates.
  function automatic logic [CW:0] rr_pick(input logic [NCH-1:0] req, input logic [CW-1:0] ptr);
    logic [CW:0] res;
    int unsigned idx;
    res = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (32'(ptr) + 32'(k)) % 32'(NCH);
      if (req[idx[CW-1:0]]) begin
        res = {1'b1, idx[CW-1:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] i);
    return {{(NCH-1){1'b0}}, 1'b1} << i;
  endfunction

  assign req_s   = bus.rden | bus.wren;
  assign pick_s  = rr_pick(req_s, ptr_r);
  assign grant_s = pick_s[CW];
  assign win_s   = pick_s[CW-1:0];

  assign bus.acq        = acq_r;
  assign bus.Dq         = dq_r;
  assign bus.RAMAddress = ram_addr_r;
  assign bus.RAMDin     = ram_din_r;
  assign bus.RAMwren    = ram_wren_r;
  assign bus.busy       = busy_r;

  // Next-state logic of the transaction sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          if (bus.wren[win_s]) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR:   state_nxt_s = IDLE;
      RD: begin
        if (RD_LAT == 2) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = CAP;
        end
      end
      WAIT:    state_nxt_s = CAP;
      CAP:     state_nxt_s = ACK;
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant pointer, RAM port and per-channel result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      ptr_r      <= CW'(NCH - 1);
      acq_r      <= '0;
      dq_r       <= '0;
      ram_addr_r <= '0;
      ram_din_r  <= '0;
      ram_wren_r <= 1'b0;
      busy_r     <= 1'b0;
    end else if (srst) begin
      state_r    <= IDLE;
      ptr_r      <= CW'(NCH - 1);
      acq_r      <= '0;
      dq_r       <= '0;
      ram_addr_r <= '0;
      ram_din_r  <= '0;
      ram_wren_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      ram_wren_r <= (state_nxt_s == WR);
      acq_r      <= '0;
      // ptr doubles as the winner register for the rest of the transaction
      if (state_r == IDLE && grant_s) begin
        ptr_r      <= win_s;
        ram_addr_r <= bus.Address[win_s*AW +: AW];
        ram_din_r  <= bus.Din[win_s*DW +: DW];
        if (bus.wren[win_s]) begin
          acq_r <= onehot(win_s);
        end
      end
      if (state_r == CAP) begin
        dq_r[ptr_r*DW +: DW] <= bus.RAMq;
        acq_r                <= onehot(ptr_r);
      end
    end
  end
endmodule
